ula_seq: RTL and testbench
==========================

ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits; legal range 2..16.
REQ-002 iCLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 iRST  input  1  synchronous, active-high reset, sampled on the rising edge of iCLK.
REQ-004 i_start  input  1  request pulse; sampled only in IDLE.
REQ-005 i_op  input  3  operation select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110/111 invalid.
REQ-006 i_a  input  WIDTH  operand A, two's complement for ADD/SUB and unsigned for MUL.
REQ-007 i_b  input  WIDTH  operand B, same encoding as i_a.
REQ-008 o_result  output  2*WIDTH  registered result.
REQ-009 o_ovf  output  1  signed overflow flag for ADD/SUB.
REQ-010 o_zero  output  1  high when the latched o_result equals 0.
REQ-011 o_err  output  1  high when the last accepted op was invalid.
REQ-012 o_busy  output  1  high while an operation is in flight.
REQ-013 o_done  output  1  one-cycle completion strobe.

Function
REQ-014 FSM states SHALL be IDLE, CALC, MUL and DONE, with every transition on the rising edge of iCLK.
REQ-015 IDLE with i_start=1 at edge k SHALL latch i_a, i_b and i_op into internal registers, then:
- go to MUL when the op is MUL;
- otherwise go to CALC.
REQ-016 CALC SHALL evaluate the latched op and, at edge k+1, write o_result and all flags, set o_done=1 and enter DONE.
REQ-017 MUL SHALL compute an unsigned shift-add product:
- one partial-product step per edge, k+1..k+WIDTH;
- at edge k+WIDTH+1, write the full 2*WIDTH-bit product, set o_done=1 and enter DONE.
REQ-018 DONE SHALL last exactly one cycle, then:
- deassert o_done at the next edge;
- go to IDLE, unless i_start=1 in that cycle, in which case the new request is accepted exactly as in REQ-015 (back-to-back).
REQ-019 o_busy SHALL be 1 in CALC and MUL, and 0 in IDLE and DONE.
REQ-020 i_start SHALL be ignored while o_busy=1; operand and op changes during busy SHALL NOT affect the in-flight result.
REQ-021 ADD/SUB result width and flags:
- o_result[WIDTH-1:0] = (A±B) mod 2^WIDTH;
- upper WIDTH bits = 0;
- o_ovf = 1 iff the signed result is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-022 AND/OR/XOR SHALL return the bitwise result zero-extended to 2*WIDTH, with o_ovf=0.
REQ-023 MUL SHALL return the exact unsigned product with o_ovf=0; no truncation is permitted.
REQ-024 An invalid op SHALL complete with CALC timing, giving o_result=0, o_err=1, o_zero=1 and o_ovf=0.
REQ-025 o_err SHALL be 0 for every valid op.
REQ-026 o_result, o_ovf, o_zero and o_err SHALL hold their values from the last completion until the next completion writes them.

Reset
REQ-027 iRST=1 at an edge SHALL force all of the following, regardless of state or i_start:
- state IDLE;
- o_result=0, o_ovf=0, o_zero=0, o_err=0, o_busy=0, o_done=0;
- internal operand, op and partial-product registers cleared to 0.
REQ-028 Reset during CALC or MUL SHALL abort the operation, with no o_done pulse and no result update.
REQ-029 Reset SHALL take priority over a simultaneous i_start; the request is dropped.

Verification (WIDTH=4, start at edge k)
REQ-030 ADD, A=4'h7, B=4'h1 -> at edge k+1: o_result=8'h08, o_ovf=1, o_zero=0, o_done=1 for exactly one cycle.
REQ-031 SUB, A=4'h3, B=4'h5 -> at edge k+1: o_result=8'h0E, o_ovf=0; SUB, A=4'h8, B=4'h1 -> o_result=8'h07, o_ovf=1.
REQ-032 MUL, A=4'hF, B=4'hF -> o_busy=1 during edges k..k+4; o_done and o_result=8'hE1 at edge k+5; an i_start pulse with new operands at edge k+2 is ignored.
REQ-033 MUL 4'h3 x 4'h2, with a second ADD (4'h1 + 4'h1) requested during the DONE cycle -> first result 8'h06; second request accepted immediately; o_result=8'h02 two edges later.
REQ-034 iRST pulsed at edge k+2 of a MUL -> o_busy=0 and all outputs 0; no o_done within the next 8 cycles.
REQ-035 i_op=3'b111 -> at edge k+1: o_result=0, o_err=1, o_zero=1, o_done=1; a following valid AND (4'hC & 4'hA) -> o_result=8'h08, o_err=0.

Source files
------------

// File: rtl/ula_seq.sv
// rtl/ula_seq.sv - sequential ALU: one-cycle ADD/SUB/logic ops, WIDTH-cycle shift-add MUL
module ula_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 i_start,
    input  logic [2:0]           i_op,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [2*WIDTH-1:0]   o_result,
    output logic                 o_ovf,
    output logic                 o_zero,
    output logic                 o_err,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int M  = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_MUL, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ovf;
    logic               r_zero;
    logic               r_err;

    logic               w_accept;
    logic               w_mul_last;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_calc_res;
    logic               w_calc_ovf;
    logic               w_calc_err;

    // DONE accepts a new request just like IDLE, giving back-to-back issue
    assign w_accept   = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_mul_last = (r_cnt == CW'(WIDTH));
    assign w_sum      = r_a + r_b;
    assign w_diff     = r_a - r_b;

    always_ff @(posedge iCLK) begin
        if (iRST) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) w_next = (i_op == OP_MUL) ? S_MUL : S_CALC;
                else         w_next = S_IDLE;
            end
            S_CALC:  w_next = S_DONE;
            S_MUL:   if (w_mul_last) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_calc_res = '0;
        w_calc_ovf = 1'b0;
        w_calc_err = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_calc_res = {{WIDTH{1'b0}}, w_sum};
                w_calc_ovf = (r_a[M] == r_b[M]) && (w_sum[M] != r_a[M]);
            end
            OP_SUB: begin
                w_calc_res = {{WIDTH{1'b0}}, w_diff};
                w_calc_ovf = (r_a[M] != r_b[M]) && (w_diff[M] != r_a[M]);
            end
            OP_AND:  w_calc_res = {{WIDTH{1'b0}}, r_a & r_b};
            OP_OR:   w_calc_res = {{WIDTH{1'b0}}, r_a | r_b};
            OP_XOR:  w_calc_res = {{WIDTH{1'b0}}, r_a ^ r_b};
            default: w_calc_err = 1'b1;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_op     <= i_op;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_cnt    <= '0;
        end else if (r_state == S_CALC) begin
            r_result <= w_calc_res;
            r_ovf    <= w_calc_ovf;
            r_zero   <= (w_calc_res == '0);
            r_err    <= w_calc_err;
        end else if (r_state == S_MUL) begin
            // one multiplier bit per edge; the final edge only publishes the product
            if (w_mul_last) begin
                r_result <= r_acc;
                r_ovf    <= 1'b0;
                r_zero   <= (r_acc == '0);
                r_err    <= 1'b0;
            end else begin
                if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
            end
        end
    end

    assign o_result = r_result;
    assign o_ovf    = r_ovf;
    assign o_zero   = r_zero;
    assign o_err    = r_err;
    assign o_busy   = (r_state == S_CALC) || (r_state == S_MUL);
    assign o_done   = (r_state == S_DONE);
endmodule

// File: tb/tb_ula_seq.sv
// tb/tb_ula_seq.sv - directed and randomized checks of ula_seq against an arithmetic model
module tb_ula_seq;
    localparam int W = 4;

    logic           iCLK = 1'b0;
    logic           iRST = 1'b0;
    logic           i_start = 1'b0;
    logic [2:0]     i_op = '0;
    logic [W-1:0]   i_a = '0;
    logic [W-1:0]   i_b = '0;
    logic [2*W-1:0] o_result;
    logic           o_ovf, o_zero, o_err, o_busy, o_done;

    int total = 0;
    int bad   = 0;

    ula_seq #(.WIDTH(W)) dut (
        .iCLK(iCLK), .iRST(iRST), .i_start(i_start), .i_op(i_op),
        .i_a(i_a), .i_b(i_b), .o_result(o_result), .o_ovf(o_ovf),
        .o_zero(o_zero), .o_err(o_err), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // returns {err, ovf, result}
    function automatic logic [2*W+1:0] model(input int op, input int a, input int b);
        int sa, sb, r, res;
        logic ovf, err;
        sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
        ovf = 1'b0; err = 1'b0; res = 0;
        case (op)
            0: begin r = sa + sb; ovf = (r > 7) || (r < -8); res = (a + b) % 16; end
            1: begin r = sa - sb; ovf = (r > 7) || (r < -8); res = (a - b + 16) % 16; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = a * b;
            default: err = 1'b1;
        endcase
        return {err, ovf, res[2*W-1:0]};
    endfunction

    task automatic start_op(input int op, input int a, input int b);
        i_op = op[2:0]; i_a = a[W-1:0]; i_b = b[W-1:0]; i_start = 1'b1;
        @(posedge iCLK); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input logic noise, output int cycles);
        cycles = 0;
        while (!o_done && cycles < 20) begin
            if (noise) begin
                i_start = 1'($urandom); i_op = 3'($urandom);
                i_a = W'($urandom); i_b = W'($urandom);
            end
            @(posedge iCLK); #1;
            cycles++;
        end
        i_start = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input int op, input int a, input int b);
        logic [2*W+1:0] e;
        e = model(op, a, b);
        chk({tag, ".result"}, 32'(o_result), 32'(e[2*W-1:0]));
        chk({tag, ".ovf"},    32'(o_ovf),    32'(e[2*W]));
        chk({tag, ".err"},    32'(o_err),    32'(e[2*W+1]));
        chk({tag, ".zero"},   32'(o_zero),   32'(e[2*W-1:0] == '0));
    endtask

    task automatic full_op(input string tag, input int op, input int a, input int b, input logic noise);
        int cyc;
        start_op(op, a, b);
        chk({tag, ".busy"}, 32'(o_busy), 32'd1);
        wait_done(noise, cyc);
        chk({tag, ".latency"}, cyc, (op == 5) ? W + 1 : 1);
        check_outputs(tag, op, a, b);
        @(posedge iCLK); #1;
        chk({tag, ".done_drop"}, 32'(o_done), 32'd0);
    endtask

    initial begin
        int cyc, seen;
        iRST = 1'b1;
        repeat (2) @(posedge iCLK);
        #1 iRST = 1'b0;
        chk("rst.result", 32'(o_result), 0);
        chk("rst.flags", {o_ovf, o_zero, o_err, o_busy, o_done}, 0);

        full_op("add_7_1", 0, 7, 1, 1'b0);
        chk("add_7_1.ovf_lit", 32'(o_ovf), 1);
        full_op("sub_3_5", 1, 3, 5, 1'b0);
        full_op("sub_8_1", 1, 8, 1, 1'b0);

        // MUL F*F with a foreign request injected at edge k+2
        start_op(5, 15, 15);
        @(posedge iCLK); #1;
        i_start = 1'b1; i_op = 3'd0; i_a = 4'h1; i_b = 4'h1;
        @(posedge iCLK); #1;
        i_start = 1'b0;
        chk("mulff.busy_k2", 32'(o_busy), 1);
        wait_done(1'b0, cyc);
        chk("mulff.latency", cyc, 3);
        chk("mulff.result", 32'(o_result), 32'hE1);
        chk("mulff.ovf", 32'(o_ovf), 0);
        @(posedge iCLK); #1;

        // MUL then back-to-back ADD during DONE
        start_op(5, 3, 2);
        wait_done(1'b0, cyc);
        chk("b2b.mul_result", 32'(o_result), 32'h06);
        i_start = 1'b1; i_op = 3'd0; i_a = 4'h1; i_b = 4'h1;
        @(posedge iCLK); #1;
        i_start = 1'b0;
        chk("b2b.accepted", 32'(o_busy), 1);
        chk("b2b.hold", 32'(o_result), 32'h06);
        @(posedge iCLK); #1;
        chk("b2b.done", 32'(o_done), 1);
        chk("b2b.add_result", 32'(o_result), 32'h02);
        @(posedge iCLK); #1;

        // reset abort during MUL, with a start request colliding with reset
        start_op(5, 15, 15);
        iRST = 1'b1; i_start = 1'b1;
        @(posedge iCLK); #1;
        iRST = 1'b0; i_start = 1'b0;
        chk("abort.busy", 32'(o_busy), 0);
        chk("abort.result", 32'(o_result), 0);
        chk("abort.flags", {o_ovf, o_zero, o_err, o_done}, 0);
        seen = 0;
        repeat (8) begin
            @(posedge iCLK); #1;
            if (o_done || o_busy) seen++;
        end
        chk("abort.no_activity", seen, 0);

        full_op("inv_7", 7, 5, 9, 1'b0);
        full_op("and_c_a", 2, 12, 10, 1'b0);
        chk("and_c_a.lit", 32'(o_result), 32'h08);
        full_op("inv_6", 6, 0, 0, 1'b0);
        full_op("xor_zero", 4, 9, 9, 1'b0);
        full_op("mul_zero", 5, 0, 13, 1'b0);

        for (int n = 0; n < 40; n++) begin
            full_op("rnd", int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
